// File: rtl/hpu_regmap_pkg.sv
// Register offsets, identification word and reset constants for the HPU register map.
package hpu_regmap_pkg;

  localparam int unsigned REG_ID          = 32'h000;
  localparam int unsigned REG_CTRL        = 32'h004;
  localparam int unsigned REG_INTR_STATUS = 32'h008;
  localparam int unsigned REG_INTR_MASK   = 32'h00C;
  localparam int unsigned REG_SCRATCH     = 32'h010;
  localparam int unsigned REG_BUSY_CYCLES = 32'h014;
  localparam int unsigned REG_CFG_BASE    = 32'h020;

  localparam int unsigned INTR_W = 8;

  localparam logic [31:0]       HPU_ID   = 32'h4850_0001;
  localparam logic [31:0]       RST_WORD = 32'h0000_0000;
  localparam logic [INTR_W-1:0] RST_INTR = 8'h00;

endpackage

// File: rtl/hpu_regmap_slave_intr.sv
// Interrupt status/mask block: W1C status with event-set priority and a registered level output.
module hpu_intr_ctrl
  import hpu_regmap_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [INTR_W-1:0] evt,
  input  logic              status_we,
  input  logic              mask_we,
  input  logic [INTR_W-1:0] wdata,
  output logic [INTR_W-1:0] status,
  output logic [INTR_W-1:0] mask,
  output logic [INTR_W-1:0] intr
);

  logic [INTR_W-1:0] clr_c;

  assign clr_c = status_we ? wdata : RST_INTR;

  // Events OR in after the clear so a same-cycle set always wins.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      status <= RST_INTR;
      mask   <= RST_INTR;
      intr   <= RST_INTR;
    end else begin
      intr   <= status & mask;
      status <= (status & ~clr_c) | evt;
      if (mask_we) mask <= wdata;
    end
  end

endmodule

// File: rtl/hpu_regmap_slave.sv
// Register-map slave terminating the PicoRV32 riscv_regmap bus: HPU control, config and status.
module hpu_regmap_slave
  import hpu_regmap_pkg::*;
#(
  parameter int unsigned DPU_REG_ADDR_WTH = 13,
  parameter int unsigned DPU_REG_DATA_WTH = 32,
  parameter int unsigned NUM_CFG          = 8
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [DPU_REG_ADDR_WTH-1:0]           riscv_regmap__waddr_i,
  input  logic                                  riscv_regmap__we_i,
  input  logic [DPU_REG_DATA_WTH-1:0]           riscv_regmap__wdata_i,
  input  logic [DPU_REG_ADDR_WTH-1:0]           riscv_regmap__raddr_i,
  input  logic                                  riscv_regmap__re_i,
  output logic [DPU_REG_DATA_WTH-1:0]           riscv_regmap__rdata_o,
  output logic                                  riscv_regmap__rdata_act_o,
  output logic [INTR_W-1:0]                     riscv_regmap__intr_o,
  input  logic [INTR_W-1:0]                     hpu_evt_i,
  output logic                                  hpu_start_o,
  output logic [NUM_CFG*DPU_REG_DATA_WTH-1:0]   hpu_cfg_o
);

  localparam int unsigned AW = DPU_REG_ADDR_WTH;
  localparam int unsigned DW = DPU_REG_DATA_WTH;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [AW-1:0]              waddr_al;
  logic [AW-1:0]              raddr_al;
  logic                       unused_addr_lsb;
  logic                       wr_ctrl, wr_status, wr_mask, wr_scratch;
  logic                       start_c;
  logic                       busy;
  logic [DW-1:0]              busy_cycles;
  logic [DW-1:0]              scratch;
  logic [NUM_CFG-1:0][DW-1:0] cfg;
  logic [INTR_W-1:0]          intr_status, intr_mask;
  logic [0:0]                 state, state_d;
  logic                       rd_take_c;
  logic [DW-1:0]              rd_mux_c;

  // Byte lanes are not supported; the two LSBs are dropped.
  assign waddr_al        = {riscv_regmap__waddr_i[AW-1:2], 2'b00};
  assign raddr_al        = {riscv_regmap__raddr_i[AW-1:2], 2'b00};
  assign unused_addr_lsb = ^{riscv_regmap__waddr_i[1:0], riscv_regmap__raddr_i[1:0]};

  assign wr_ctrl    = riscv_regmap__we_i && (waddr_al == AW'(REG_CTRL));
  assign wr_status  = riscv_regmap__we_i && (waddr_al == AW'(REG_INTR_STATUS));
  assign wr_mask    = riscv_regmap__we_i && (waddr_al == AW'(REG_INTR_MASK));
  assign wr_scratch = riscv_regmap__we_i && (waddr_al == AW'(REG_SCRATCH));
  assign start_c    = wr_ctrl && riscv_regmap__wdata_i[0];

  assign hpu_cfg_o = cfg;

  hpu_intr_ctrl u_intr (
    .clk       (clk),
    .resetn    (resetn),
    .evt       (hpu_evt_i),
    .status_we (wr_status),
    .mask_we   (wr_mask),
    .wdata     (riscv_regmap__wdata_i[INTR_W-1:0]),
    .status    (intr_status),
    .mask      (intr_mask),
    .intr      (riscv_regmap__intr_o)
  );

  // Writable registers, start pulse, busy flag and saturating busy counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hpu_start_o <= 1'b0;
      busy        <= 1'b0;
      busy_cycles <= DW'(RST_WORD);
      scratch     <= DW'(RST_WORD);
      cfg         <= '0;
    end else begin
      hpu_start_o <= start_c;
      if (wr_scratch) scratch <= riscv_regmap__wdata_i;
      for (int k = 0; k < int'(NUM_CFG); k++) begin
        if (riscv_regmap__we_i && (waddr_al == AW'(REG_CFG_BASE + 4 * k)))
          cfg[k] <= riscv_regmap__wdata_i;
      end
      if (start_c) begin
        busy_cycles <= '0;
      end else if (busy && (busy_cycles != '1)) begin
        busy_cycles <= busy_cycles + DW'(1);
      end
      if (start_c) begin
        busy <= 1'b1;
      end else if (hpu_evt_i[0]) begin
        busy <= 1'b0;
      end
    end
  end

  // Read mux on pre-edge register values.
  always_comb begin
    rd_mux_c = '0;
    if (raddr_al == AW'(REG_ID))          rd_mux_c = DW'(HPU_ID);
    if (raddr_al == AW'(REG_CTRL))        rd_mux_c = DW'(busy);
    if (raddr_al == AW'(REG_INTR_STATUS)) rd_mux_c = DW'(intr_status);
    if (raddr_al == AW'(REG_INTR_MASK))   rd_mux_c = DW'(intr_mask);
    if (raddr_al == AW'(REG_SCRATCH))     rd_mux_c = scratch;
    if (raddr_al == AW'(REG_BUSY_CYCLES)) rd_mux_c = busy_cycles;
    for (int k = 0; k < int'(NUM_CFG); k++) begin
      if (raddr_al == AW'(REG_CFG_BASE + 4 * k)) rd_mux_c = cfg[k];
    end
  end

  // Ack FSM: ACK state blocks sampling, so a held request is re-taken every other cycle.
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d   = state;
    rd_take_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (riscv_regmap__re_i) begin
          rd_take_c = 1'b1;
          state_d   = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      riscv_regmap__rdata_act_o <= 1'b0;
      riscv_regmap__rdata_o     <= DW'(RST_WORD);
    end else begin
      riscv_regmap__rdata_act_o <= rd_take_c;
      if (rd_take_c) riscv_regmap__rdata_o <= rd_mux_c;
    end
  end

endmodule

// File: tb/tb_hpu_regmap_slave.sv
// Randomized and directed bench for hpu_regmap_slave against a register-map reference model.
module tb_hpu_regmap_slave;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;
  localparam int unsigned NC = 8;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [AW-1:0]    waddr = '0;
  logic             we = 1'b0;
  logic [DW-1:0]    wdata = '0;
  logic [AW-1:0]    raddr = '0;
  logic             re = 1'b0;
  logic [DW-1:0]    rdata;
  logic             rdata_act;
  logic [7:0]       intr;
  logic [7:0]       evt = '0;
  logic             start;
  logic [NC*DW-1:0] cfg;

  always #5 clk = ~clk;

  hpu_regmap_slave #(.DPU_REG_ADDR_WTH(AW), .DPU_REG_DATA_WTH(DW), .NUM_CFG(NC)) dut (
    .clk                       (clk),
    .resetn                    (resetn),
    .riscv_regmap__waddr_i     (waddr),
    .riscv_regmap__we_i        (we),
    .riscv_regmap__wdata_i     (wdata),
    .riscv_regmap__raddr_i     (raddr),
    .riscv_regmap__re_i        (re),
    .riscv_regmap__rdata_o     (rdata),
    .riscv_regmap__rdata_act_o (rdata_act),
    .riscv_regmap__intr_o      (intr),
    .hpu_evt_i                 (evt),
    .hpu_start_o               (start),
    .hpu_cfg_o                 (cfg)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference model: the register map as plain variables.
  logic [31:0] m_cfg [NC];
  logic [31:0] m_scratch, m_cnt, m_rdata;
  logic [7:0]  m_status, m_mask, m_intr;
  bit          m_busy, m_act, m_start;

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    int unsigned w = 32'(a) / 4;
    if (w == 0) return 32'h4850_0001;
    if (w == 1) return {31'b0, m_busy};
    if (w == 2) return {24'b0, m_status};
    if (w == 3) return {24'b0, m_mask};
    if (w == 4) return m_scratch;
    if (w == 5) return m_cnt;
    if (w >= 8 && w < 8 + NC) return m_cfg[w-8];
    return 32'h0;
  endfunction

  // One clock: predict from pre-edge state and inputs, advance, then compare all outputs.
  task automatic step();
    logic [31:0] rd_v = model_read(raddr);
    bit take = re && !m_act;
    int unsigned ww = 32'(waddr) / 4;
    bit st = we && (ww == 1) && wdata[0];
    logic [7:0] clr = (we && ww == 2) ? wdata[7:0] : 8'h00;
    @(posedge clk);
    if (!resetn) begin
      foreach (m_cfg[k]) m_cfg[k] = '0;
      m_scratch = '0; m_cnt = '0; m_rdata = '0;
      m_status = '0; m_mask = '0; m_intr = '0;
      m_busy = 0; m_act = 0; m_start = 0;
    end else begin
      m_intr  = m_status & m_mask;
      if (take) m_rdata = rd_v;
      m_act   = take;
      m_start = st;
      m_status = (m_status & ~clr) | evt;
      if (we && ww == 3) m_mask = wdata[7:0];
      if (we && ww == 4) m_scratch = wdata;
      if (we && ww >= 8 && ww < 8 + NC) m_cfg[ww-8] = wdata;
      if (st) m_cnt = 0;
      else if (m_busy && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (st) m_busy = 1;
      else if (evt[0]) m_busy = 0;
    end
    #1;
    chk("ack", 32'(rdata_act), 32'(m_act));
    chk("rdata", rdata, m_rdata);
    chk("intr", 32'(intr), 32'(m_intr));
    chk("start", 32'(start), 32'(m_start));
    for (int k = 0; k < int'(NC); k++) chk($sformatf("cfg%0d", k), cfg[k*32 +: 32], m_cfg[k]);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [31:0] d, output int lat);
    int n = 0;
    re = 1'b1; raddr = a;
    do begin
      step();
      n++;
    end while (!rdata_act && n < 4);
    if (!rdata_act) chk("rd_timeout", 32'(rdata_act), 32'd1);
    d = rdata; lat = n;
    re = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] tbl [16] = '{13'h000, 13'h004, 13'h008, 13'h00C, 13'h010, 13'h014, 13'h018,
                                13'h01C, 13'h020, 13'h024, 13'h028, 13'h02C, 13'h034, 13'h03C,
                                13'h040, 13'h1FFC};
    return tbl[$urandom_range(0, 15)] | AW'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] v;
    int lat;
    int acks;

    repeat (3) step();
    chk("rst_ack", 32'(rdata_act), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_intr", 32'(intr), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_cfg_or", 32'(|cfg), 32'd0);
    resetn = 1'b1;
    step();

    rd(13'h000, v, lat);
    chk("id", v, 32'h4850_0001);
    chk("id_lat", 32'(lat), 32'd1);

    wr(13'h024, 32'hA5A5_0003);
    chk("cfg1_out", cfg[63:32], 32'hA5A5_0003);
    wr(13'h010, 32'h1234_5678);
    rd(13'h024, v, lat); chk("cfg1_rd", v, 32'hA5A5_0003);
    rd(13'h010, v, lat); chk("scratch_rd", v, 32'h1234_5678);
    rd(13'h1FFC, v, lat); chk("unmapped_rd", v, 32'h0);

    wr(13'h00C, 32'h81);
    evt = 8'h83; step(); evt = 8'h00;
    step();
    chk("intr_after_evt", 32'(intr), 32'h81);
    rd(13'h008, v, lat); chk("status_83", v, 32'h83);
    wr(13'h008, 32'h01);
    rd(13'h008, v, lat); chk("status_w1c", v, 32'h82);
    chk("intr_w1c", 32'(intr), 32'h80);
    evt = 8'h80; wr(13'h008, 32'h80); evt = 8'h00;
    rd(13'h008, v, lat); chk("status_set_wins", v, 32'h82);
    chk("intr_set_wins", 32'(intr), 32'h80);

    wr(13'h004, 32'h1);
    chk("start_pulse", 32'(start), 32'd1);
    step();
    chk("start_one_cycle", 32'(start), 32'd0);
    repeat (98) step();
    evt = 8'h01; step(); evt = 8'h00;
    rd(13'h014, v, lat); chk("busy_cycles_100", v, 32'd100);
    repeat (5) step();
    rd(13'h014, v, lat); chk("busy_cycles_hold", v, 32'd100);
    rd(13'h004, v, lat); chk("busy_idle", v, 32'd0);
    wr(13'h004, 32'h1);
    rd(13'h014, v, lat); chk("busy_restart", v, 32'd0);
    rd(13'h004, v, lat); chk("busy_set", v, 32'd1);
    evt = 8'h01; step(); evt = 8'h00;

    acks = 0;
    re = 1'b1; raddr = 13'h010;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin we = 1'b1; waddr = 13'h010; wdata = 32'hCAFE_F00D; end
      step();
      we = 1'b0;
      if (rdata_act) begin
        acks++;
        chk("held_rd_data", rdata, (acks == 1) ? 32'h1234_5678 : 32'hCAFE_F00D);
      end
    end
    re = 1'b0;
    chk("held_rd_acks", 32'(acks), 32'd3);

    re = 1'b1; raddr = 13'h010; resetn = 1'b0;
    step();
    chk("rst_mid_rd_ack", 32'(rdata_act), 32'd0);
    step();
    re = 1'b0; resetn = 1'b1;
    step();
    chk("rst_mid_rd_noack", 32'(rdata_act), 32'd0);
    rd(13'h010, v, lat); chk("scratch_after_rst", v, 32'h0);

    for (int c = 0; c < 1500; c++) begin
      we    = ($urandom_range(0, 3) == 0);
      waddr = pick_addr();
      wdata = $urandom;
      if (!re && $urandom_range(0, 2) == 0) begin re = 1'b1; raddr = pick_addr(); end
      evt    = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
      resetn = ($urandom_range(0, 299) != 0);
      step();
      if (rdata_act) re = 1'b0;
    end
    we = 1'b0; re = 1'b0; evt = 8'h00; resetn = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hpu_regmap_slave.md
# hpu_regmap_slave

Register-map slave that terminates the PicoRV32 SoC `riscv_regmap__*` bus and exposes HPU control, configuration and status registers. It sits directly downstream of the picosoc regmap master and produces the 8-bit interrupt vector the CPU consumes. It also contains a busy-cycle counter for run profiling. It replaces the behavioural external memory model used in simulation.

## Interface

**Parameters**
- `DPU_REG_ADDR_WTH`, default 13: byte address width.
- `DPU_REG_DATA_WTH`, default 32: data width. Only 32 is supported.
- `NUM_CFG`, default 8: number of RW config words.

**Ports** (clock and reset first)
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `riscv_regmap__waddr_i` in ADDR: write byte address.
- `riscv_regmap__we_i` in 1: single-cycle write strobe.
- `riscv_regmap__wdata_i` in DATA: write data.
- `riscv_regmap__raddr_i` in ADDR: read byte address, held until ack.
- `riscv_regmap__re_i` in 1: read request, held until ack.
- `riscv_regmap__rdata_o` out DATA: read data.
- `riscv_regmap__rdata_act_o` out 1: read ack, one-cycle pulse.
- `riscv_regmap__intr_o` out 8: level interrupts to the CPU.
- `hpu_evt_i` in 8: event pulses from the HPU. Bit 0 is `done`.
- `hpu_start_o` out 1: one-cycle start pulse.
- `hpu_cfg_o` out NUM_CFG×32: flattened config words. Word 0 occupies bits [31:0].

## Operation

- Addresses are word-aligned. `addr[1:0]` is ignored.
- Register map:
  - 0x000 ID, RO: 32'h4850_0001.
  - 0x004 CTRL: write bit0=1 pulses `hpu_start_o`; reads return {31'b0, busy}.
  - 0x008 INTR_STATUS, W1C: bit i is set by `hpu_evt_i[i]`.
  - 0x00C INTR_MASK, RW.
  - 0x010 SCRATCH, RW.
  - 0x014 BUSY_CYCLES, RO.
  - 0x020 + 4k, for k < NUM_CFG: CFG[k], RW.
- Unmapped reads return 0. Unmapped writes are ignored.
- Interrupt output: `riscv_regmap__intr_o` is a register updated every cycle to `INTR_STATUS & INTR_MASK`, using the pre-edge values.
- If an event and a W1C hit the same status bit in the same cycle, the set wins.
- Busy flag: set by a start write and cleared by `hpu_evt_i[0]`. If start and done occur in the same cycle, busy ends at 1.
- BUSY_CYCLES:
  - cleared to 0 on a start write;
  - increments by 1 each cycle while busy;
  - saturates at 32'hFFFF_FFFF;
  - holds its value when idle.
- A start write while already busy restarts the counter and keeps busy at 1.
- Reset values: all registers 0, all outputs 0. `hpu_cfg_o` is 0.

## Timing

- **Write:** `we_i` is sampled at edge N. The register updates at N, and its effect is visible on outputs after N.
  - `hpu_start_o` is high during cycle N+1 only.
  - A mask write affects `intr_o` one cycle later, at edge N+1.
- **Read:** the request is sampled at edge N while `re_i && !rdata_act_o`.
  - `rdata_o` and `rdata_act_o` are registered at edge N and valid during cycle N+1.
  - `rdata_act_o` is high for exactly one cycle.
  - `rdata_o` holds its value until the next ack.
- **Held requests:** if `re_i` stays high after an ack, it counts as a new request. Acks are therefore at most one every 2 cycles.
- **Simultaneous write and read:** a `we_i` and a read request at the same edge are both serviced. The read returns the pre-write value.
- **Reading INTR_STATUS:** returns the value before that edge's event or W1C update.
- **Reset mid-read:** `rdata_act_o` goes to 0 and the pending ack is dropped. The master must reissue the read.
- **Event latency:** an event at edge N sets status at N. If the bit is unmasked, `intr_o` rises at N+1.

## Structure

- Package `hpu_regmap_pkg` holds:
  - address offset localparams (`REG_ID`, `REG_CTRL`, `REG_INTR_STATUS`, `REG_INTR_MASK`, `REG_SCRATCH`, `REG_BUSY_CYCLES`, `REG_CFG_BASE`);
  - `HPU_ID` = 32'h4850_0001;
  - the reset-value constants.
- Sub-module `hpu_intr_ctrl` holds status/mask, W1C, set-wins priority and the registered `intr_o`.
- The top level contains:
  - write decode;
  - read mux plus ack FSM with states IDLE→ACK→IDLE;
  - CFG array;
  - busy flag and cycle counter.

## Test plan

- **Reset and ID:** release reset, then read 0x000. Expect `rdata_o`=32'h4850_0001 with an ack 1 cycle after `re` is sampled. All outputs are 0 during reset.
- **CFG/SCRATCH:** write 0xA5A5_0003 to 0x024 and 0x1234_5678 to 0x010, then read both back.
  - Expect `hpu_cfg_o[63:32]`=0xA5A5_0003 after the write edge.
  - Unmapped read of 0x1FFC returns 0.
- **Interrupts:**
  - Set mask 0x81, then pulse `hpu_evt_i`=0x83. Expect status 0x83 and `intr_o`=0x81 one cycle later.
  - W1C 0x01 gives status 0x82 and `intr_o`=0x80.
  - A W1C of 0x80 in the same cycle as `evt[7]` leaves bit 7 set.
- **Busy counter:**
  - Write CTRL=1. Expect `hpu_start_o` for 1 cycle and busy=1.
  - Pulse `evt[0]` 100 cycles later. BUSY_CYCLES reads 100 and stays there.
  - A restart clears it to 0.
- **Held read:** hold `re_i` for 6 cycles. Expect `rdata_act_o` pulses on alternating cycles (3 acks). A write issued alongside a read returns the old value.
- **Reset mid-read:** assert `resetn`=0 in the cycle after `re` is sampled. Expect no ack, and SCRATCH reads 0 after reset.
